// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and helpers for the sprite column mover
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  localparam logic DIR_DN = 1'b0;
  localparam logic DIR_UP = 1'b1;

  function automatic int pid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_step_clamp.sv
// rtl/sprite_step_clamp.sv - one step up or down, clamped to [Y_MIN, Y_MAX]
module sprite_step_clamp
  import sprite_pkg::*;
#(
  parameter int Y_W   = 7,
  parameter int STEP  = 10,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 110
) (
  input  logic [Y_W-1:0] y,
  input  logic           dir,
  output logic [Y_W-1:0] new_y
);

  localparam logic [Y_W:0] STEP_E = (Y_W+1)'(STEP);
  localparam logic [Y_W:0] MIN_E  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0] MAX_E  = (Y_W+1)'(Y_MAX);

  logic [Y_W:0] y_e;
  logic [Y_W:0] sum;
  logic [Y_W:0] diff;

  assign y_e  = {1'b0, y};
  assign sum  = y_e + STEP_E;
  assign diff = y_e - STEP_E;

  // The extra top bit of diff flags wrap below zero; the compare catches a nonzero floor.
  always_comb begin
    new_y = y;
    if (dir == DIR_UP) begin
      if (diff[Y_W] || (y_e < STEP_E + MIN_E)) new_y = MIN_E[Y_W-1:0];
      else                                      new_y = diff[Y_W-1:0];
    end else begin
      if (sum > MAX_E) new_y = MAX_E[Y_W-1:0];
      else             new_y = sum[Y_W-1:0];
    end
  end

endmodule

// File: rtl/sprite_column_mover.sv
// rtl/sprite_column_mover.sv - per-player y position control with erase/draw command stream
module sprite_column_mover
  import sprite_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int STEP        = 10,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 110,
  parameter int Y_START     = 0,
  parameter int X_SPACING   = 118,
  localparam int PID_W      = pid_width(NUM_PLAYERS)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_PLAYERS-1:0]     move_dn,
  input  logic [NUM_PLAYERS-1:0]     move_up,
  output logic [NUM_PLAYERS*Y_W-1:0] y_pos,
  output logic [NUM_PLAYERS-1:0]     at_top,
  output logic [NUM_PLAYERS-1:0]     at_bottom,
  output logic                       draw_valid,
  input  logic                       draw_ready,
  output logic [X_W-1:0]             draw_x,
  output logic [Y_W-1:0]             draw_y,
  output logic                       draw_erase,
  output logic [PID_W-1:0]           draw_player,
  output logic                       busy
);

  localparam logic [Y_W-1:0] Y_START_C = Y_W'(Y_START);
  localparam logic [Y_W-1:0] Y_MIN_C   = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX_C   = Y_W'(Y_MAX);

  state_t                 state;
  logic [NUM_PLAYERS-1:0] pend_valid;
  logic [NUM_PLAYERS-1:0] pend_dir;
  logic [Y_W-1:0]         y_reg [NUM_PLAYERS];
  logic [Y_W-1:0]         cur_new;

  logic                   pick_found;
  logic [PID_W-1:0]       pick_idx;
  logic [Y_W-1:0]         pick_y;
  logic                   pick_dir;
  logic [X_W-1:0]         pick_x;
  logic [Y_W-1:0]         clamp_y;
  logic                   pend_clr;

  // Walk from the top index down so the lowest pending player wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_y     = '0;
    pick_dir   = DIR_DN;
    pick_x     = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (pend_valid[p]) begin
        pick_found = 1'b1;
        pick_idx   = PID_W'(p);
        pick_y     = y_reg[p];
        pick_dir   = pend_dir[p];
        pick_x     = X_W'(p * X_SPACING);
      end
    end
  end

  sprite_step_clamp #(
    .Y_W   (Y_W),
    .STEP  (STEP),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX)
  ) u_clamp (
    .y     (pick_y),
    .dir   (pick_dir),
    .new_y (clamp_y)
  );

  assign pend_clr = (state == ST_IDLE) && pick_found;

  // A pulse is taken only while the slot is empty; a slot being cleared this edge still counts as full.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid <= '0;
      pend_dir   <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (pend_clr && (pick_idx == PID_W'(p))) begin
          pend_valid[p] <= 1'b0;
        end else if (!pend_valid[p] && (move_dn[p] ^ move_up[p])) begin
          pend_valid[p] <= 1'b1;
          pend_dir[p]   <= move_up[p] ? DIR_UP : DIR_DN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      draw_valid  <= 1'b0;
      draw_erase  <= 1'b0;
      draw_x      <= '0;
      draw_y      <= '0;
      draw_player <= '0;
      cur_new     <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) y_reg[p] <= Y_START_C;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found && (clamp_y != pick_y)) begin
            state       <= ST_ERASE;
            draw_valid  <= 1'b1;
            draw_erase  <= 1'b1;
            draw_x      <= pick_x;
            draw_y      <= pick_y;
            draw_player <= pick_idx;
            cur_new     <= clamp_y;
          end
        end
        ST_ERASE: begin
          if (draw_ready) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (draw_player == PID_W'(p)) y_reg[p] <= cur_new;
            end
            state      <= ST_DRAW;
            draw_erase <= 1'b0;
            draw_y     <= cur_new;
          end
        end
        ST_DRAW: begin
          if (draw_ready) begin
            state      <= ST_IDLE;
            draw_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          draw_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pos
    assign y_pos[g*Y_W +: Y_W] = y_reg[g];
    assign at_top[g]           = (y_reg[g] == Y_MIN_C);
    assign at_bottom[g]        = (y_reg[g] == Y_MAX_C);
  end

endmodule

// File: tb/tb_sprite_column_mover.sv
// tb/tb_sprite_column_mover.sv - directed and random checks against a behavioural model
module tb_sprite_column_mover;

  localparam int NP   = 2;
  localparam int STEP = 10;
  localparam int YMIN = 0;
  localparam int YMAX = 110;
  localparam int XSP  = 118;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    move_dn = '0;
  logic [1:0]    move_up = '0;
  logic          draw_ready = 1'b1;

  logic [13:0]   y_pos, y_pos2;
  logic [1:0]    at_top, at_top2, at_bottom, at_bottom2;
  logic          draw_valid, draw_valid2, draw_erase, draw_erase2, busy, busy2;
  logic [7:0]    draw_x, draw_x2;
  logic [6:0]    draw_y, draw_y2;
  logic [0:0]    draw_player, draw_player2;

  int total = 0;
  int bad   = 0;

  int my [NP];
  bit mpend [NP];
  bit mdir [NP];
  int mphase, mp, mold, mnew;

  always #5 clk = ~clk;

  sprite_column_mover dut (
    .clk(clk), .resetn(resetn), .move_dn(move_dn), .move_up(move_up),
    .y_pos(y_pos), .at_top(at_top), .at_bottom(at_bottom),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_x(draw_x),
    .draw_y(draw_y), .draw_erase(draw_erase), .draw_player(draw_player), .busy(busy)
  );

  sprite_column_mover #(.Y_MAX(105)) dut2 (
    .clk(clk), .resetn(resetn), .move_dn(move_dn), .move_up(move_up),
    .y_pos(y_pos2), .at_top(at_top2), .at_bottom(at_bottom2),
    .draw_valid(draw_valid2), .draw_ready(draw_ready), .draw_x(draw_x2),
    .draw_y(draw_y2), .draw_erase(draw_erase2), .draw_player(draw_player2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int mclamp(input int y, input bit up);
    if (up) return (y - STEP < YMIN) ? YMIN : y - STEP;
    return (y + STEP > YMAX) ? YMAX : y + STEP;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      my[p] = 0; mpend[p] = 0; mdir[p] = 0;
    end
    mphase = 0; mp = 0; mold = 0; mnew = 0;
  endtask

  task automatic model_edge(input logic [1:0] dn, input logic [1:0] up, input logic rdy);
    bit old_pend [NP];
    bit done;
    int ny;
    old_pend = mpend;
    done = 0;
    if (mphase == 0) begin
      for (int p = 0; p < NP; p++) begin
        if (old_pend[p] && !done) begin
          done = 1;
          mpend[p] = 0;
          ny = mclamp(my[p], mdir[p]);
          if (ny != my[p]) begin
            mphase = 1; mp = p; mold = my[p]; mnew = ny;
          end
        end
      end
    end else if (mphase == 1) begin
      if (rdy) begin my[mp] = mnew; mphase = 2; end
    end else if (rdy) begin
      mphase = 0;
    end
    for (int p = 0; p < NP; p++) begin
      if ((dn[p] ^ up[p]) && !old_pend[p]) begin mpend[p] = 1; mdir[p] = up[p]; end
    end
  endtask

  task automatic check_all();
    chk("valid", draw_valid, mphase != 0);
    chk("busy", busy, mphase != 0);
    for (int p = 0; p < NP; p++) begin
      chk("y_pos", y_pos[p*7 +: 7], my[p]);
      chk("at_top", at_top[p], my[p] == YMIN);
      chk("at_bottom", at_bottom[p], my[p] == YMAX);
    end
    if (mphase != 0) begin
      chk("erase", draw_erase, mphase == 1);
      chk("draw_y", draw_y, (mphase == 1) ? mold : mnew);
      chk("draw_x", draw_x, mp * XSP);
      chk("player", draw_player, mp);
    end
  endtask

  task automatic tick();
    logic [1:0] cdn, cup;
    logic crdy;
    cdn = move_dn; cup = move_up; crdy = draw_ready;
    @(posedge clk);
    model_edge(cdn, cup, crdy);
    #1;
    move_dn = '0;
    move_up = '0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    move_dn = '0; move_up = '0; draw_ready = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic beat_stalled();
    draw_ready = 1'b0;
    repeat (3) tick();
    draw_ready = 1'b1;
    tick();
    draw_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_y_pos", y_pos, 14'd0);
    chk("rst_at_top", at_top, 2'b11);
    chk("rst_at_bottom", at_bottom, 2'b00);
    chk("rst_valid", draw_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // single move down of player 0
    draw_ready = 1'b1;
    move_dn = 2'b01;
    tick();
    chk("p0_pend_novalid", draw_valid, 1'b0);
    tick();
    chk("p0_erase_valid", draw_valid, 1'b1);
    chk("p0_erase_flag", draw_erase, 1'b1);
    chk("p0_erase_x", draw_x, 8'd0);
    chk("p0_erase_y", draw_y, 7'd0);
    tick();
    chk("p0_draw_flag", draw_erase, 1'b0);
    chk("p0_draw_y", draw_y, 7'd10);
    chk("p0_y_pos", y_pos[6:0], 7'd10);
    tick();
    chk("p0_idle", draw_valid, 1'b0);

    // both players in one cycle, plotter stalls 3 cycles per beat
    draw_ready = 1'b0;
    move_dn = 2'b11;
    tick();
    tick();
    chk("stall_first_player", draw_player, 1'b0);
    chk("stall_first_y", draw_y, 7'd10);
    beat_stalled();
    beat_stalled();
    tick();
    chk("stall_second_x", draw_x, 8'd118);
    chk("stall_second_player", draw_player, 1'b1);
    beat_stalled();
    beat_stalled();
    draw_ready = 1'b1;
    tick();
    chk("stall_y0", y_pos[6:0], 7'd20);
    chk("stall_y1", y_pos[13:7], 7'd10);

    // conflicting up+down on the same player is dropped
    move_dn = 2'b01; move_up = 2'b01;
    repeat (4) begin
      tick();
      chk("conflict_novalid", draw_valid, 1'b0);
    end
    chk("conflict_y0", y_pos[6:0], 7'd20);

    // move up at the top bound does nothing
    do_reset();
    move_up = 2'b01;
    repeat (4) begin
      tick();
      chk("top_novalid", draw_valid, 1'b0);
      chk("top_flag", at_top[0], 1'b1);
    end

    // player 1 walks to the bottom; the Y_MAX=105 copy clamps its last step
    for (int i = 0; i < 12; i++) begin
      move_dn = 2'b10;
      tick();
      tick();
      if (i == 10) chk("bot_erase_y2", draw_y2, 7'd100);
      if (i == 11) begin
        chk("bot_extra_novalid", draw_valid, 1'b0);
        chk("bot_extra_novalid2", draw_valid2, 1'b0);
      end
      tick();
      if (i == 10) begin
        chk("bot_draw_y", draw_y, 7'd110);
        chk("bot_draw_y2", draw_y2, 7'd105);
      end
      tick();
    end
    chk("bot_flag", at_bottom[1], 1'b1);
    chk("bot_y2", y_pos2[13:7], 7'd105);
    chk("bot_flag2", at_bottom2[1], 1'b1);

    // random pulses and back-pressure
    for (int i = 0; i < 600; i++) begin
      move_dn[0] = ($urandom_range(0, 4) == 0);
      move_dn[1] = ($urandom_range(0, 4) == 0);
      move_up[0] = ($urandom_range(0, 4) == 0);
      move_up[1] = ($urandom_range(0, 4) == 0);
      draw_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // reset while the draw beat is stalled
    do_reset();
    move_dn = 2'b01;
    tick();
    tick();
    tick();
    draw_ready = 1'b0;
    chk("mid_draw_valid", draw_valid, 1'b1);
    chk("mid_draw_flag", draw_erase, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_valid", draw_valid, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_y_pos", y_pos, 14'd0);
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    draw_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_idle", draw_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_column_mover.md
# sprite_column_mover

Parametrised multi-player sprite position controller for the VGA game datapath. It generalises the single-player "move down one step" logic to N players, both directions, configurable step and bounds. Each accepted move is emitted as an erase-old / draw-new pair over a valid/ready handshake to the pixel drawing unit. It sits between the keyboard/button decode logic and the VGA plotter.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of independent sprites (≥1)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- STEP, 10, pixels moved per request (>0)
- Y_MIN, 0, top bound
- Y_MAX, 110, bottom bound (Y_MIN ≤ Y_MAX < 2^Y_W)
- Y_START, 0, reset y for every player
- X_SPACING, 118, fixed x of player p is p*X_SPACING (must fit X_W)

Ports (PID_W = max(1, clog2(NUM_PLAYERS))):
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- move_dn  in  NUM_PLAYERS  one-cycle request pulses, per player
- move_up  in  NUM_PLAYERS  one-cycle request pulses, per player
- y_pos  out  NUM_PLAYERS*Y_W  committed y per player, player p at [p*Y_W +: Y_W]
- at_top  out  NUM_PLAYERS  y_pos[p] == Y_MIN
- at_bottom  out  NUM_PLAYERS  y_pos[p] == Y_MAX
- draw_valid  out  1  draw command valid
- draw_ready  in  1  plotter accepts command
- draw_x  out  X_W  sprite x
- draw_y  out  Y_W  sprite y
- draw_erase  out  1  1 = paint background, 0 = paint sprite
- draw_player  out  PID_W  player index
- busy  out  1  FSM not IDLE

## Operation
- Per-player pending register {valid, dir}. A pulse sets it if not already pending; while pending, further pulses for that player are ignored. move_up and move_dn on the same player in the same cycle: discarded.
- FSM states: IDLE, ERASE, DRAW.
- IDLE: if any pending, pick the lowest-index pending player. Clear its pending bit, capture index and dir, compute new_y, go to ERASE. If new_y == current y (at the bound), clear pending and stay IDLE. No draw is issued.
- new_y is computed in Y_W+1 bits. Down: min(y+STEP, Y_MAX). Up: y−STEP, clamped to Y_MIN; underflow is detected through the extra bit.
- ERASE: draw_valid=1, draw_erase=1, draw_y=old y. On valid&&ready, commit y_pos[p] ← new_y and go to DRAW.
- DRAW: draw_valid=1, draw_erase=0, draw_y=new y. On valid&&ready, go to IDLE.
- draw_x = player*X_SPACING. Payload is held stable while draw_valid && !draw_ready.
- Requests that arrive during a transaction, including for the serviced player, are latched into pending and serviced afterwards.

## Timing
- Reset values: y_pos all Y_START, pending clear, state IDLE, draw_valid 0, draw_erase 0, draw_x 0, draw_y 0, draw_player 0, busy 0. at_top/at_bottom follow from Y_START.
- Reset mid-transaction: all of the above apply immediately and asynchronously. The in-flight move is lost and y_pos is not committed.
- Pulse sampled at edge k → pending visible cycle k+1 → ERASE (draw_valid high) from edge k+2.
- With draw_ready held 1: ERASE and DRAW take 1 cycle each. A transaction occupies 3 cycles including IDLE.
- y_pos, at_top and at_bottom change at the edge that completes the ERASE handshake.
- The handshake completes only when valid && ready in the same cycle. draw_ready has no combinational path to draw_valid.

## Structure
- Shared package sprite_pkg holds:
  - the FSM state enum
  - a clog2-based PID width function
  - the dir encoding (DIR_DN=0, DIR_UP=1)
- Sub-module sprite_step_clamp: combinational (y, dir) → new_y with STEP/Y_MIN/Y_MAX parameters. It is instantiated once and unit-testable on its own.
- Lowest-index pick is inline in the top.

## Test plan
- Reset with defaults → y_pos={0,0}, at_top=2'b11, at_bottom=2'b00, draw_valid=0, busy=0.
- move_dn[0] pulse, draw_ready=1 → two cycles later (x=0, y=0, erase=1), next cycle (x=0, y=10, erase=0); y_pos[0]=10.
- Player 1: 11 move_dn pulses spaced 4 cycles → y steps to 110 with at_bottom[1]=1. Twelfth pulse → no draw_valid. With Y_MAX=105 variant, from 100 → draws y=105.
- move_dn[0] and move_dn[1] same cycle, draw_ready low 3 cycles per beat → player 0 pair first, then player 1 (x=118). Payload stable while stalled.
- Same-cycle move_up[0]+move_dn[0] → no activity. move_up[0] at y=0 → pending clears, no draw, at_top[0] stays 1.
- resetn low during DRAW with draw_ready=0 → draw_valid drops immediately. After release y_pos=Y_START and no pending work.
